exec_stage: RTL and testbench



---
 rtl/exec_stage_if.sv | 35 +++
 rtl/exec_stage.sv | 158 +++++++++++++++
 tb/tb_exec_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/exec_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_stage_if
//  Description : Bundles the issue, writeback and EX/MEM result signals of
//                exec_stage. The master side drives instructions and
//                writebacks; the slave side is the stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface exec_stage_if;
  // issue side
  logic        in_valid;
  logic [31:0] instruction;
  // writeback side
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  // EX/MEM outputs
  logic        valid_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic [1:0]  alu_ctrl_q;
  logic        illegal_q;
  logic        ovf_q;

  modport master (
    output in_valid, instruction, wr_en, wr_addr, wr_data,
    input  valid_q, result_q, zero_q, alu_ctrl_q, illegal_q, ovf_q
  );

  modport slave (
    input  in_valid, instruction, wr_en, wr_addr, wr_data,
    output valid_q, result_q, zero_q, alu_ctrl_q, illegal_q, ovf_q
  );
endinterface
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exec_stage
//  Description : Combined decode / execute / EX-MEM stage. Decodes a 32-bit
//                instruction, reads operands from a 32x32 register file
//                (r0 hardwired to zero, write-through bypass), runs a 2-bit
//                ALU (ADD/SUB/AND/OR) and captures the result in the EX/MEM
//                register one cycle later.
//                Optional feature macro: EXEC_STAGE_OVF_EN builds the signed
//                overflow flag for ADD/SUB; otherwise ovf_q is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module exec_stage (
  input  wire logic   clock,
  input  wire logic   reset,
  exec_stage_if.slave bus
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ---------------------------------------------------------------- decode
  logic [3:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [1:0]  alu_ctrl;
  logic        imm_sel;
  logic        illegal;
  logic        unused_bits;

  assign opcode      = bus.instruction[31:28];
  assign rs          = bus.instruction[25:21];
  assign rt          = bus.instruction[20:16];
  assign imm         = bus.instruction[15:0];
  assign alu_ctrl    = opcode[1:0];
  assign imm_sel     = opcode[3];
  assign illegal     = opcode[2];
  // bits [27:26] carry no meaning for this stage
  assign unused_bits = ^bus.instruction[27:26];

  // --------------------------------------------------------- register file
  logic [31:0] regs [0:31];

  // Writeback port; reset clears every entry and wins over wr_en.
  // Entry 0 is never written so it stays at its cleared value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (bus.wr_en && (bus.wr_addr != 5'd0)) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // Operand reads: r0 reads zero, a same-cycle write is forwarded.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (bus.wr_en && (bus.wr_addr == rs)) rs_val = bus.wr_data;
    if (bus.wr_en && (bus.wr_addr == rt)) rt_val = bus.wr_data;
    if (rs == 5'd0) rs_val = 32'd0;
    if (rt == 5'd0) rt_val = 32'd0;
  end

  // ------------------------------------------------------------------- ALU
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] result;

  assign op1  = rs_val;
  assign sum  = op1 + op2;
  assign diff = op1 - op2;

  // Second operand: register, or immediate sign-extended for arithmetic
  // and zero-extended for logic ops.
  always_comb begin
    op2 = rt_val;
    if (imm_sel) begin
      if (alu_ctrl[1]) op2 = {16'd0, imm};
      else             op2 = {{16{imm[15]}}, imm};
    end
  end

  // ALU function select.
  always_comb begin
    result = 32'd0;
    case (alu_ctrl)
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      default: result = 32'd0;
    endcase
  end

  // ------------------------------------------------------ EX/MEM register
  // Capture on valid issue; an illegal op captures a fixed bubble-like
  // pattern; idle cycles drop valid and hold the payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.valid_q    <= 1'b0;
      bus.result_q   <= 32'd0;
      bus.zero_q     <= 1'b1;
      bus.alu_ctrl_q <= 2'b00;
      bus.illegal_q  <= 1'b0;
    end else if (bus.in_valid) begin
      bus.valid_q <= 1'b1;
      if (illegal) begin
        bus.result_q   <= 32'd0;
        bus.zero_q     <= 1'b1;
        bus.alu_ctrl_q <= 2'b00;
        bus.illegal_q  <= 1'b1;
      end else begin
        bus.result_q   <= result;
        bus.zero_q     <= (result == 32'd0);
        bus.alu_ctrl_q <= alu_ctrl;
        bus.illegal_q  <= 1'b0;
      end
    end else begin
      bus.valid_q <= 1'b0;
    end
  end

`ifdef EXEC_STAGE_OVF_EN
  logic ovf;

  // Signed overflow: ADD when equal-sign operands give a different-sign
  // result; SUB when operand signs differ and the result sign leaves op1's.
  always_comb begin
    ovf = 1'b0;
    case (alu_ctrl)
      ALU_ADD: ovf = (op1[31] == op2[31]) && (sum[31]  != op1[31]);
      ALU_SUB: ovf = (op1[31] != op2[31]) && (diff[31] != op1[31]);
      default: ovf = 1'b0;
    endcase
  end

  // Overflow flag follows the same capture/hold rules as the payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      bus.ovf_q <= illegal ? 1'b0 : ovf;
    end
  end
`else
  assign bus.ovf_q = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_stage
//  Description : Directed self-checking bench for exec_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exec_stage;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic exp_ovf;

  exec_stage_if bus ();

  exec_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one edge and land 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, 2'b00, rs, rt, imm};
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_en    = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm);
    bus.instruction = mk(op, rs, rt, imm);
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid    = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic z,
                            input logic [1:0] alu, input logic ill);
    check({tag, ".valid"}, {31'd0, bus.valid_q}, 32'd1);
    check({tag, ".result"}, bus.result_q, res);
    check({tag, ".zero"}, {31'd0, bus.zero_q}, {31'd0, z});
    check({tag, ".alu"}, {30'd0, bus.alu_ctrl_q}, {30'd0, alu});
    check({tag, ".illegal"}, {31'd0, bus.illegal_q}, {31'd0, ill});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef EXEC_STAGE_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    bus.in_valid    = 1'b1;
    bus.instruction = mk(4'h0, 5'd0, 5'd0, 16'h1234);
    bus.wr_en       = 1'b1;
    bus.wr_addr     = 5'd5;
    bus.wr_data     = 32'h55;
    reset           = 1'b1;

    // reset for two cycles with valid issue and a competing write
    step();
    step();
    check("rst.valid", {31'd0, bus.valid_q}, 32'd0);
    check("rst.result", bus.result_q, 32'd0);
    check("rst.zero", {31'd0, bus.zero_q}, 32'd1);
    check("rst.alu", {30'd0, bus.alu_ctrl_q}, 32'd0);
    check("rst.illegal", {31'd0, bus.illegal_q}, 32'd0);
    check("rst.ovf", {31'd0, bus.ovf_q}, 32'd0);
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.in_valid = 1'b0;

    // reg5 must have been cleared, not written
    issue(4'h3, 5'd5, 5'd0, 16'd0);
    expect_out("r5", 32'd0, 1'b1, 2'b11, 1'b0);

    wr(5'd1, 32'h5);
    wr(5'd2, 32'h3);

    issue(4'h0, 5'd1, 5'd2, 16'd0);
    expect_out("add", 32'h8, 1'b0, 2'b00, 1'b0);

    issue(4'h1, 5'd1, 5'd1, 16'd0);
    expect_out("sub0", 32'h0, 1'b1, 2'b01, 1'b0);

    issue(4'h1, 5'd0, 5'd1, 16'd0);
    expect_out("subneg", 32'hFFFF_FFFB, 1'b0, 2'b01, 1'b0);

    // idle cycle: valid drops, payload holds
    step();
    check("hold.valid", {31'd0, bus.valid_q}, 32'd0);
    check("hold.result", bus.result_q, 32'hFFFF_FFFB);
    check("hold.alu", {30'd0, bus.alu_ctrl_q}, 32'd1);

    issue(4'h8, 5'd1, 5'd0, 16'hFFFF);
    expect_out("addi", 32'h4, 1'b0, 2'b00, 1'b0);

    issue(4'hA, 5'd2, 5'd0, 16'hFFFF);
    expect_out("andi", 32'h3, 1'b0, 2'b10, 1'b0);

    issue(4'hB, 5'd1, 5'd0, 16'h8000);
    expect_out("ori", 32'h0000_8005, 1'b0, 2'b11, 1'b0);

    issue(4'h8, 5'd0, 5'd0, 16'h8000);
    expect_out("addi_sx", 32'hFFFF_8000, 1'b0, 2'b00, 1'b0);

    // bypass: write r3 and read it in the same cycle
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h10;
    issue(4'h3, 5'd3, 5'd0, 16'd0);
    bus.wr_en   = 1'b0;
    expect_out("bypass", 32'h10, 1'b0, 2'b11, 1'b0);

    issue(4'h3, 5'd0, 5'd3, 16'd0);
    expect_out("r3", 32'h10, 1'b0, 2'b11, 1'b0);

    // r0 stays zero, including same-cycle write to address 0
    wr(5'd0, 32'hFF);
    issue(4'h3, 5'd0, 5'd0, 16'd0);
    expect_out("r0", 32'h0, 1'b1, 2'b11, 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'hFF;
    issue(4'h0, 5'd0, 5'd0, 16'd0);
    bus.wr_en   = 1'b0;
    expect_out("r0byp", 32'h0, 1'b1, 2'b00, 1'b0);

    // illegal ops, including one with nonzero alu bits
    issue(4'h4, 5'd1, 5'd2, 16'd0);
    expect_out("ill4", 32'h0, 1'b1, 2'b00, 1'b1);
    issue(4'h5, 5'd1, 5'd2, 16'd0);
    expect_out("ill5", 32'h0, 1'b1, 2'b00, 1'b1);
    check("ill5.ovf", {31'd0, bus.ovf_q}, 32'd0);

    // overflow
    wr(5'd4, 32'h7FFF_FFFF);
    wr(5'd6, 32'h1);
    wr(5'd7, 32'h8000_0000);
    issue(4'h0, 5'd4, 5'd6, 16'd0);
    expect_out("addovf", 32'h8000_0000, 1'b0, 2'b00, 1'b0);
    check("addovf.ovf", {31'd0, bus.ovf_q}, {31'd0, exp_ovf});
    issue(4'h3, 5'd4, 5'd6, 16'd0);
    expect_out("or_noovf", 32'h7FFF_FFFF, 1'b0, 2'b11, 1'b0);
    check("or.ovf", {31'd0, bus.ovf_q}, 32'd0);
    issue(4'h1, 5'd0, 5'd7, 16'd0);
    expect_out("subovf", 32'h8000_0000, 1'b0, 2'b01, 1'b0);
    check("subovf.ovf", {31'd0, bus.ovf_q}, {31'd0, exp_ovf});
    issue(4'h1, 5'd7, 5'd7, 16'd0);
    expect_out("sub_noovf", 32'h0, 1'b1, 2'b01, 1'b0);
    check("sub_noovf.ovf", {31'd0, bus.ovf_q}, 32'd0);

    // mid-stream reset discards the instruction and clears the file
    reset = 1'b1;
    issue(4'h0, 5'd1, 5'd2, 16'd0);
    reset = 1'b0;
    check("mrst.valid", {31'd0, bus.valid_q}, 32'd0);
    check("mrst.result", bus.result_q, 32'd0);
    check("mrst.zero", {31'd0, bus.zero_q}, 32'd1);
    issue(4'h0, 5'd1, 5'd2, 16'd0);
    expect_out("mrst.rf", 32'h0, 1'b1, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
